// File: rtl/sw_pkg.sv
// Shared defaults and the event record layout for the switch sampler.
package sw_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int SAMPLE_DIV_DEF = 500;
  localparam int STABLE_N_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] rise;
    logic [WIDTH_DEF-1:0] fall;
  } sw_evt_t;

endpackage

// File: rtl/sw_sampler_if.sv
// Valid/ready event stream: the producer owns valid and data, the consumer owns ready.
interface sw_evt_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sw_evt_fifo.sv
// Event queue with registered occupancy; the read side is a valid/ready stream
// whose data reads zero while empty.
module sw_evt_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          drop,
  sw_evt_if.master      rd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          not_empty;
  logic          pop;
  logic          push_ok;

  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty && rd.ready;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    push_ok   = push && ((count_q != FULL_CNT) || pop);
    drop      = push && !push_ok;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd.valid = not_empty;
  assign rd.data  = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sw_sampler.sv
// Switch debouncer: synchronizes raw levels, samples them on a divided tick and
// queues one rise/fall event per accepted change.
module sw_sampler
  import sw_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int STABLE_N   = STABLE_N_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             overflow
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_N);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             overflow_q, overflow_d;
  logic             tick;
  logic             push;
  logic             drop;
  logic [2*WIDTH-1:0] push_data;

  sw_evt_if #(.DW(2*WIDTH)) evt_if ();

  always_comb begin
    sync1_d    = sw_in;
    sync2_d    = sync1_q;
    tick       = (div_q == DIV_LAST);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    prev_d     = prev_q;
    stable_d   = stable_q;
    state_d    = state_q;
    push       = 1'b0;
    if (tick) begin
      if (sync2_q == prev_q) begin
        if (stable_q != CNT_SAT) begin
          stable_d = stable_q + CNT_W'(1);
        end else begin
          stable_d = stable_q;
        end
        // Accept once the run of identical samples is long enough and it is news.
        if ((stable_d == CNT_SAT) && (prev_q != state_q)) begin
          state_d = prev_q;
          push    = 1'b1;
        end else begin
          push    = 1'b0;
        end
      end else begin
        prev_d   = sync2_q;
        stable_d = '0;
      end
    end else begin
      push = 1'b0;
    end
    push_data  = {prev_q & ~state_q, ~prev_q & state_q};
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_q      <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      state_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_q      <= div_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  sw_evt_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .drop      (drop),
    .rd        (evt_if.master)
  );

  assign evt_if.ready          = evt_ready;
  assign evt_valid             = evt_if.valid;
  assign {evt_rise, evt_fall}  = evt_if.data;
  assign sw_state              = state_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_sw_sampler.sv
// Self-checking bench for sw_sampler: directed corner sequences plus random
// stimulus, all compared against an event-level reference model.
module tb_sw_sampler;

  localparam int W     = 16;
  localparam int DIV   = 4;
  localparam int SN    = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_state, evt_rise, evt_fall;
  logic         overflow;

  sw_evt_if #(.DW(2*W)) mon ();

  sw_sampler #(.WIDTH(W), .SAMPLE_DIV(DIV), .STABLE_N(SN), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_state  (sw_state),
    .evt_valid (mon.valid),
    .evt_ready (mon.ready),
    .evt_rise  (evt_rise),
    .evt_fall  (evt_fall),
    .overflow  (overflow)
  );

  assign mon.data = {evt_rise, evt_fall};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a sampled-run debouncer must do, expressed as run lengths and a queue.
  typedef struct { logic [W-1:0] rise; logic [W-1:0] fall; } ev_t;
  ev_t          m_q[$];
  logic [W-1:0] m_pipe1, m_pipe2, m_prev, m_state;
  int           m_phase, m_run, m_before;
  bit           m_ovf, m_push, m_pop;
  ev_t          m_ev;

  always @(posedge clk) begin
    if (rst) begin
      m_pipe1 = '0; m_pipe2 = '0; m_prev = '0; m_state = '0;
      m_phase = 0; m_run = 1; m_ovf = 1'b0; m_q.delete();
    end else begin
      m_push = 1'b0;
      if (m_phase == DIV - 1) begin
        if (m_pipe2 == m_prev) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_prev = m_pipe2;
          m_run  = 1;
        end
        if (m_run > SN && m_prev != m_state) begin
          m_ev.rise = m_prev & ~m_state;
          m_ev.fall = ~m_prev & m_state;
          m_state   = m_prev;
          m_push    = 1'b1;
        end
      end
      m_before = m_q.size();
      m_pop    = (m_before != 0) && mon.ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_before < DEPTH || m_pop) m_q.push_back(m_ev);
        else m_ovf = 1'b1;
      end
      m_pipe2 = m_pipe1;
      m_pipe1 = sw_in;
      m_phase = (m_phase + 1) % DIV;
    end
  end

  function automatic bit predict_push();
    int run;
    if (m_phase != DIV - 1) return 1'b0;
    run = (m_pipe2 == m_prev) ? m_run + 1 : 1;
    return (run > SN) && (m_pipe2 != m_state);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sw_state", sw_state, m_state);
      check("model_evt_valid", W'(mon.valid), W'(m_q.size() != 0));
      check("model_evt_rise", evt_rise, (m_q.size() != 0) ? m_q[0].rise : '0);
      check("model_evt_fall", evt_fall, (m_q.size() != 0) ? m_q[0].fall : '0);
      check("model_overflow", W'(overflow), W'(m_ovf));
    end
  end

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;
  vec_t tbl[10];

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_one();
    mon.ready = 1'b1;
    @(negedge clk);
    mon.ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  budget;
    bit  hit;

    tbl[0] = '{16'h1111, 16'h0011, 16'hEE00};
    tbl[1] = '{16'h2222, 16'h2222, 16'h1111};
    tbl[2] = '{16'h3333, 16'h1111, 16'h0000};
    tbl[3] = '{16'h4444, 16'h4444, 16'h3333};
    tbl[4] = '{16'h5555, 16'h1111, 16'h0000};
    tbl[5] = '{16'h000A, 16'h000A, 16'h0000};
    tbl[6] = '{16'h00A0, 16'h00A0, 16'h000A};
    tbl[7] = '{16'h0A00, 16'h0A00, 16'h00A0};
    tbl[8] = '{16'hA000, 16'hA000, 16'h0A00};
    tbl[9] = '{16'hFFFF, 16'h5FFF, 16'h0000};

    mon.ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_sw_state", sw_state, 16'h0000);
    check("reset_evt_valid", W'(mon.valid), 16'h0000);
    check("reset_evt_rise", evt_rise, 16'h0000);
    check("reset_evt_fall", evt_fall, 16'h0000);
    check("reset_overflow", W'(overflow), 16'h0000);
    rst = 1'b0;

    // Clean edge, launched so the synchronizer output lands right on a tick.
    budget = 0;
    while (m_phase != 1 && budget < 2*DIV) begin @(negedge clk); budget++; end
    sw_in = 16'h0001;
    lat = 0;
    while (sw_state !== 16'h0001 && lat < 30) begin @(negedge clk); lat++; end
    check("clean_latency_ok", W'(lat <= 2 + SN*DIV + 1), 16'h0001);
    check("clean_valid", W'(mon.valid), 16'h0001);
    check("clean_rise", evt_rise, 16'h0001);
    check("clean_fall", evt_fall, 16'h0000);
    pop_one();
    check("clean_drained", W'(mon.valid), 16'h0000);

    // Bounce on bit 3: a new level every tick, then held high.
    for (int i = 0; i < 5; i++) begin
      sw_in = sw_in ^ 16'h0008;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        check("bounce_quiet", W'(mon.valid), 16'h0000);
      end
    end
    settle();
    check("bounce_rise", evt_rise, 16'h0008);
    check("bounce_fall", evt_fall, 16'h0000);
    check("bounce_state", sw_state, 16'h0009);
    pop_one();
    check("bounce_single", W'(mon.valid), 16'h0000);

    // Multi-bit change is one event.
    sw_in = 16'h00FF;
    settle();
    pop_one();
    sw_in = 16'hFF00;
    settle();
    check("multi_rise", evt_rise, 16'hFF00);
    check("multi_fall", evt_fall, 16'h00FF);
    pop_one();
    check("multi_single", W'(mon.valid), 16'h0000);

    // Overflow: five settled changes with nobody reading.
    for (int i = 0; i < 5; i++) begin
      sw_in = tbl[i].sw;
      settle();
    end
    check("ovf_flag", W'(overflow), 16'h0001);
    check("ovf_state", sw_state, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      check("ovf_rise", evt_rise, tbl[i].rise);
      check("ovf_fall", evt_fall, tbl[i].fall);
      pop_one();
    end
    check("ovf_fifth_dropped", W'(mon.valid), 16'h0000);
    settle();
    check("ovf_sticky", W'(overflow), 16'h0001);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sw_in = 16'h0000;
    check("ovf_cleared", W'(overflow), 16'h0000);
    settle();

    // Full queue with a pop on the very push cycle.
    for (int i = 5; i < 9; i++) begin
      sw_in = tbl[i].sw;
      settle();
    end
    sw_in = tbl[9].sw;
    hit = 1'b0;
    budget = 0;
    while (!hit && budget < 40) begin
      mon.ready = predict_push();
      hit = mon.ready;
      @(negedge clk);
      budget++;
    end
    mon.ready = 1'b0;
    check("simul_push_seen", W'(hit), 16'h0001);
    check("simul_no_overflow", W'(overflow), 16'h0000);
    check("simul_state", sw_state, 16'hFFFF);
    for (int i = 6; i < 10; i++) begin
      check("simul_rise", evt_rise, tbl[i].rise);
      check("simul_fall", evt_fall, tbl[i].fall);
      pop_one();
    end
    check("simul_drained", W'(mon.valid), 16'h0000);

    // Reset with two queued events and a change still debouncing.
    sw_in = 16'h0003;
    settle();
    sw_in = 16'h0007;
    settle();
    sw_in = 16'h00F0;
    repeat (6) @(negedge clk);
    check("midrst_queued", W'(mon.valid), 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", W'(mon.valid), 16'h0000);
    check("midrst_state", sw_state, 16'h0000);
    check("midrst_overflow", W'(overflow), 16'h0000);
    settle();
    check("post_rst_rise", evt_rise, 16'h00F0);
    check("post_rst_fall", evt_fall, 16'h0000);
    pop_one();
    check("post_rst_single", W'(mon.valid), 16'h0000);

    // Random levels, hold times and reader stalls.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) sw_in = W'($urandom);
      else sw_in = sw_in ^ (W'(1) << $urandom_range(0, W-1));
      for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
        mon.ready = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    mon.ready = 1'b0;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_sampler.md
SW_SAMPLER -- requirements
Module: sw_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of switch/key inputs.
REQ-002 SHALL have parameter SAMPLE_DIV, default 500: clk cycles between sample ticks.
REQ-003 SHALL have parameter STABLE_N, default 4: consecutive identical samples required to accept a change.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two: event queue depth.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port sw_in, input, WIDTH: raw asynchronous switch levels.
REQ-008 SHALL have port sw_state, output, WIDTH: debounced switch levels.
REQ-009 SHALL have port evt_valid, output, 1: event available at the queue head.
REQ-010 SHALL have port evt_ready, input, 1: consumer accepts the head event.
REQ-011 SHALL have port evt_rise, output, WIDTH: bits that went 0->1 in the head event.
REQ-012 SHALL have port evt_fall, output, WIDTH: bits that went 1->0 in the head event.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when an event is dropped.

Function
REQ-014 SHALL pass sw_in through a two-flop synchronizer per bit before any other use.
REQ-015 SHALL run a divider counter 0..SAMPLE_DIV-1 that wraps to 0 and asserts a one-cycle tick on the wrap cycle.
REQ-016 SHALL, on each tick, compare the synchronized vector with the previous sample: if equal, increment stable_cnt, saturating at STABLE_N; if different, store the new sample and clear stable_cnt to 0.
REQ-017 SHALL, on a tick where stable_cnt reaches STABLE_N and the sample differs from sw_state, load sw_state with the sample in the next cycle.
REQ-018 SHALL push one event in that same cycle, with rise = sample & ~sw_state and fall = ~sample & sw_state, using the sw_state value before the update.
REQ-019 SHALL generate at most one event per tick; a multi-bit change is a single event.
REQ-020 SHALL assert evt_valid whenever the FIFO is non-empty; evt_rise and evt_fall SHALL show the head entry and SHALL drive zero when the FIFO is empty.
REQ-021 SHALL pop the head on a cycle with evt_valid and evt_ready both high; evt_ready while empty SHALL have no effect.
REQ-022 SHALL, on a simultaneous push and pop while the FIFO is non-empty, keep occupancy unchanged and keep entry order.
REQ-023 SHALL, on a simultaneous push and pop while the FIFO is full, accept the push and SHALL NOT drop the event.
REQ-024 SHALL, on a push while full with no pop, drop the new event, leave the FIFO contents unchanged, and set overflow; sw_state SHALL still update.
REQ-025 SHALL hold overflow until rst.
REQ-026 SHALL keep sw_state latency of (2 sync + STABLE_N ticks + 1) cycles at most, relative to a clean input edge.

Reset
REQ-027 SHALL, while rst is high at a clk edge, clear the divider, stable_cnt, the previous sample, the synchronizers, sw_state, the FIFO pointers/count, and overflow, so that evt_valid, evt_rise, and evt_fall read 0.
REQ-028 SHALL let rst asserted mid-debounce or with a non-empty FIFO discard all pending state, with no event emitted for the aborted change.
REQ-029 SHALL, after rst deasserts with switches already high, report them through the normal debounce path as one rise event.

Structure
REQ-030 SHALL place the WIDTH, SAMPLE_DIV, STABLE_N, and FIFO_DEPTH defaults and a packed event typedef {rise, fall} in the shared package sw_pkg.
REQ-031 SHALL implement the queue as one sub-module, sw_evt_fifo: synchronous, registered occupancy, with valid/ready on the read side.
REQ-032 SHALL keep the synchronizer, divider, and debounce logic in sw_sampler itself.

Verification
REQ-033 SHALL cover a clean edge: SAMPLE_DIV=4, STABLE_N=2, sw_in 0x0000->0x0001 held -> one event with rise=0x0001, fall=0 and sw_state=0x0001 within 2+2*4+1 cycles.
REQ-034 SHALL cover bounce: bit 3 toggles each tick for 5 ticks, then settles high -> exactly one event with rise=0x0008, and no event during the toggling.
REQ-035 SHALL cover a multi-bit change: sw_state 0x00FF, sw_in 0xFF00 -> a single event with rise=0xFF00, fall=0x00FF.
REQ-036 SHALL cover overflow: evt_ready=0 with 5 distinct settled changes and FIFO_DEPTH=4 -> 4 events held, the 5th dropped, overflow=1, and sw_state equal to the 5th value.
REQ-037 SHALL cover full with simultaneous push and pop: evt_ready pulsed on the push cycle -> no drop, overflow stays 0, events in order.
REQ-038 SHALL cover reset mid-operation: rst pulsed with 2 queued events and a pending change -> evt_valid=0, sw_state=0, overflow=0 the next cycle.
